// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-enqueue handshake between the register file (master)
// and the UART transmitter (slave).
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter. Bytes are enqueued through the
// uart_tx_if slave port and serialised LSB-first on txd with a frame format
// (data bits, stop bits, ticks per bit) latched at the start of each frame.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit
// after the data bits.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int OS_DEFAULT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic [4:0] word_length,
  input  logic       Num_stop_bits,
  input  logic       oversample_by_3,
  uart_tx_if.slave   tx,
  output logic       txd,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       tx_done
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int OS_MAX = (OS_DEFAULT > 3) ? OS_DEFAULT : 3;
  localparam int OSW    = $clog2(OS_MAX);  // wide enough for os-1

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  state_e         state_q;
  logic [OSW-1:0] tick_q, os_m1_q;
  logic [2:0]     bit_cnt_q, nbits_m1_q;
  logic           stop2_q, stop_cnt_q;
  logic           txd_q, busy_q, done_q;
  logic [7:0]     shift_q;
`ifdef UART_TX_PARITY_EN
  logic           par_q;
`endif
  logic           push, pop, bit_end, last_stop, shift_en;

  // Effective data bits minus one, clamping the programmed length to 5..8.
  function automatic logic [2:0] nbits_m1(input logic [4:0] wl);
    if (wl < 5'd5)      return 3'd4;
    else if (wl > 5'd8) return 3'd7;
    else                return 3'(wl - 5'd1);
  endfunction

  // Ticks per bit minus one for the selected oversample ratio.
  function automatic logic [OSW-1:0] os_m1(input logic by3);
    return by3 ? OSW'(2) : OSW'(OS_DEFAULT - 1);
  endfunction

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tx.tx_ready = !fifo_full;
  assign push        = tx.tx_valid && !fifo_full;

  assign bit_end   = baud_tick && (tick_q == os_m1_q);
  // Final stop period ends: either single stop, or second of two.
  assign last_stop = (state_q == STOP) && bit_end && !(stop2_q && !stop_cnt_q);
  // A new frame is loaded from idle, or straight out of the last stop bit.
  assign pop       = !fifo_empty && ((state_q == IDLE) || last_stop);
  assign shift_en  = (state_q == DATA) && bit_end;

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

  // Write pointer advances on every accepted byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_ptr_q <= '0;
    else if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx.tx_data;
  end

  // Shift register: loaded on pop, shifted right at the end of each data bit.
  always_ff @(posedge clk) begin
    if (pop)           shift_q <= mem_q[rd_ptr_q[AW-1:0]];
    else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
  end

`ifdef UART_TX_PARITY_EN
  // Running even parity over the data bits as they leave the shifter.
  always_ff @(posedge clk) begin
    if (pop)           par_q <= 1'b0;
    else if (shift_en) par_q <= par_q ^ shift_q[0];
  end
`endif

  // Frame state machine with registered txd/busy/tx_done and frame-format latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      nbits_m1_q <= 3'd7;
      os_m1_q    <= OSW'(OS_DEFAULT - 1);
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last_stop;
      if (pop) begin
        state_q    <= START;
        rd_ptr_q   <= rd_ptr_q + (AW + 1)'(1);
        tick_q     <= '0;
        bit_cnt_q  <= '0;
        stop_cnt_q <= 1'b0;
        nbits_m1_q <= nbits_m1(word_length);
        os_m1_q    <= os_m1(oversample_by_3);
        stop2_q    <= Num_stop_bits;
        txd_q      <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        if (baud_tick && (state_q != IDLE))
          tick_q <= bit_end ? '0 : tick_q + OSW'(1);
        case (state_q)
          IDLE: begin
          end
          START: begin
            if (bit_end) begin
              state_q <= DATA;
              txd_q   <= shift_q[0];
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_cnt_q == nbits_m1_q) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
                txd_q   <= par_q ^ shift_q[0];
`else
                state_q <= STOP;
                txd_q   <= 1'b1;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                txd_q     <= shift_q[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              if (stop2_q && !stop_cnt_q) begin
                stop_cnt_q <= 1'b1;
              end else begin
                state_q    <= IDLE;
                stop_cnt_q <= 1'b0;
                busy_q     <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven bench for uart_tx with a scoreboard of queued
// bytes and a tick-level line monitor that rebuilds each expected frame.
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [11:0] EXP_A5 = 12'h54A;
`else
  localparam int PB = 0;
  localparam logic [11:0] EXP_A5 = 12'h34A;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [4:0] word_length = 5'd8;
  logic       Num_stop_bits = 1'b0;
  logic       oversample_by_3 = 1'b0;
  logic       txd, busy, fifo_empty, fifo_full, tx_done;

  uart_tx_if txif();

  uart_tx #(.FIFO_DEPTH(4), .OS_DEFAULT(16)) dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick),
    .word_length(word_length), .Num_stop_bits(Num_stop_bits),
    .oversample_by_3(oversample_by_3), .tx(txif),
    .txd(txd), .busy(busy), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 baud_tick = ~baud_tick;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int eff_bits(input int wl);
    if (wl < 5) return 5;
    if (wl > 8) return 8;
    return wl;
  endfunction

  // Scoreboard and line monitor state
  logic [7:0]  sb[$];
  int          mon_st = 0, bit_i = 0, tk = 0, ntot = 0, fos = 16, nb = 8;
  int          frame_no = 0, frames_done = 0, done_cnt = 0;
  int          busy_ticks = 0, last_ticks = 0;
  logic [15:0] ebits;
  logic [11:0] cap = '0;
  logic [7:0]  bv;
  logic        ok = 1'b1, par = 1'b0, pend_done = 1'b0, expect_b2b = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_st = 0; pend_done = 1'b0; expect_b2b = 1'b0; busy_ticks = 0;
    end else begin
      if (pend_done) begin
        pend_done = 1'b0;
        chk("tx_done_pulse", tx_done, 1);
        chk("busy_after_stop", busy, sb.size() != 0);
        expect_b2b = (sb.size() != 0);
      end
      if (tx_done) begin
        done_cnt++;
        last_ticks = busy_ticks;
        busy_ticks = 0;
      end
      if (baud_tick && busy) busy_ticks++;
      if (baud_tick) begin
        if (mon_st == 0) begin
          if (expect_b2b) begin
            chk("b2b_no_gap", txd, 0);
            expect_b2b = 1'b0;
          end
          if (txd == 1'b0) begin
            chk("frame_expected", sb.size() != 0, 1);
            if (sb.size() == 0) begin
              mon_st = 2;
            end else begin
              bv = sb.pop_front();
              nb = eff_bits(int'(word_length));
              fos = oversample_by_3 ? 3 : 16;
              ebits = '1;
              ebits[0] = 1'b0;
              par = 1'b0;
              for (int i = 0; i < nb; i++) begin
                ebits[1+i] = bv[i];
                par = par ^ bv[i];
              end
              if (PB == 1) ebits[1+nb] = par;
              ntot = 1 + nb + PB + (Num_stop_bits ? 2 : 1);
              bit_i = 0; tk = 0; ok = 1'b1; cap = '0;
              mon_st = 1;
              frame_no++;
            end
          end
        end else if (mon_st == 2) begin
          if (txd) mon_st = 0;
        end
        if (mon_st == 1) begin
          if (txd !== ebits[bit_i]) ok = 1'b0;
          if (tk == 0) cap[bit_i] = txd;
          tk++;
          if (tk == fos) begin
            chk($sformatf("frame%0d_bit%0d_exp%0d", frame_no, bit_i, ebits[bit_i]), ok, 1);
            ok = 1'b1; tk = 0; bit_i++;
            if (bit_i == ntot) begin
              mon_st = 0;
              pend_done = 1'b1;
              frames_done++;
            end
          end
        end
      end
    end
  end

  // Push one byte while idle and check the 2-cycle push-to-start latency.
  task automatic push_idle(input logic [7:0] d, input string nm);
    txif.tx_data = d;
    txif.tx_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_ready"}, txif.tx_ready, 1);
    sb.push_back(d);
    @(posedge clk);
    #1 txif.tx_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_empty"}, fifo_empty, 0);
    chk({nm, "_lat1_txd"}, txd, 1);
    @(negedge clk);
    chk({nm, "_lat2_txd"}, txd, 0);
    chk({nm, "_lat2_busy"}, busy, 1);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (k < budget && tx_done !== 1'b1);
    chk({nm, "_done_seen"}, tx_done, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [4:0] wl;
    logic       stop2;
    logic       os3;
    int         exp_ticks;
  } vec_t;
  vec_t vecs[6];

  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic       exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txif.tx_valid = 1'b0;
    txif.tx_data  = 8'h00;
    vecs[0] = '{8'hA5, 5'd8,  1'b0, 1'b0, (10 + PB) * 16};
    vecs[1] = '{8'h1F, 5'd3,  1'b1, 1'b1, (8 + PB) * 3};
    vecs[2] = '{8'h3C, 5'd12, 1'b0, 1'b1, (10 + PB) * 3};
    vecs[3] = '{8'h55, 5'd6,  1'b1, 1'b0, (9 + PB) * 16};
    vecs[4] = '{8'h00, 5'd7,  1'b0, 1'b1, (9 + PB) * 3};
    vecs[5] = '{8'hFF, 5'd5,  1'b0, 1'b0, (7 + PB) * 16};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ready", txif.tx_ready, 1);
    chk("rst_done", tx_done, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      word_length     = vecs[v].wl;
      Num_stop_bits   = vecs[v].stop2;
      oversample_by_3 = vecs[v].os3;
      push_idle(vecs[v].data, $sformatf("v%0d", v));
      wait_done(2000, $sformatf("v%0d", v));
      @(negedge clk);
      chk($sformatf("v%0d_frame_ticks", v), last_ticks, vecs[v].exp_ticks);
      if (v == 0) chk("a5_line_bits", cap, EXP_A5);
      repeat (3) @(posedge clk);
      #1;
    end

    // FIFO full: six back-to-back pushes, sixth dropped
    word_length = 5'd8; Num_stop_bits = 1'b0; oversample_by_3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      txif.tx_data  = burst[i];
      txif.tx_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("burst%0d_ready", i), txif.tx_ready, exp_rdy[i]);
      if (exp_rdy[i]) sb.push_back(burst[i]);
      @(posedge clk);
      #1;
    end
    txif.tx_valid = 1'b0;
    @(negedge clk);
    chk("burst_full", fifo_full, 1);
    chk("burst_not_empty", fifo_empty, 0);
    for (int i = 0; i < 5; i++) wait_done(1000, $sformatf("burst%0d", i));
    repeat (4) @(posedge clk);
    #1;
    chk("burst_drained", fifo_empty, 1);

    // Config change mid-frame: first frame keeps 16 ticks/bit
    txif.tx_data = 8'h96; txif.tx_valid = 1'b1;
    @(negedge clk); sb.push_back(8'h96);
    @(posedge clk); #1 txif.tx_data = 8'h3C;
    @(negedge clk); sb.push_back(8'h3C);
    @(posedge clk); #1 txif.tx_valid = 1'b0;
    repeat (70) @(posedge clk);
    #1 oversample_by_3 = 1'b1;
    wait_done(1000, "cfg1");
    @(negedge clk);
    chk("cfg1_ticks", last_ticks, (10 + PB) * 16);
    wait_done(1000, "cfg2");
    @(negedge clk);
    chk("cfg2_ticks", last_ticks, (10 + PB) * 3);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-frame with a second byte waiting in the FIFO
    oversample_by_3 = 1'b0;
    txif.tx_data = 8'h3C; txif.tx_valid = 1'b1;
    @(negedge clk); sb.push_back(8'h3C);
    @(posedge clk); #1 txif.tx_data = 8'h5A;
    @(negedge clk); sb.push_back(8'h5A);
    @(posedge clk); #1 txif.tx_valid = 1'b0;
    repeat (78) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_txd_low", txd, 0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #2;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_empty", fifo_empty, 1);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    oversample_by_3 = 1'b1;
    push_idle(8'hC6, "after_rst");
    wait_done(1000, "after_rst");
    @(negedge clk);
    chk("after_rst_ticks", last_ticks, (10 + PB) * 3);

`ifdef UART_TX_PARITY_EN
    repeat (3) @(posedge clk);
    #1;
    word_length = 5'd8; Num_stop_bits = 1'b0; oversample_by_3 = 1'b1;
    push_idle(8'h07, "par");
    wait_done(1000, "par");
    @(negedge clk);
    chk("parity_bit", cap[9], 1);
`endif

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("done_pulse_count", done_cnt, frames_done);
    chk("scoreboard_drained", sb.size(), 0);
    chk("end_idle_txd", txd, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit stage of the UART, directly downstream of the control register file. It accepts bytes into a small transmit FIFO and serialises each one onto `txd` using the frame format programmed in CNTRL0: word length, stop bits and oversample ratio. It returns FIFO status and a frame-done pulse, which the register file reports through CNTRL1.

## Interface
- `FIFO_DEPTH`, default 4: transmit FIFO entries; must be a power of 2, ≥2.
- `OS_DEFAULT`, default 16: baud ticks per bit when `oversample_by_3`=0.

- `clk` input 1: system clock.
- `reset_n` input 1: reset, asynchronous assert, active-low.
- `baud_tick` input 1: one-cycle strobe at oversample rate.
- `word_length` input 5: data bits per frame. Values <5 are treated as 5; values >8 are treated as 8.
- `Num_stop_bits` input 1: 0 selects 1 stop bit; 1 selects 2 stop bits.
- `oversample_by_3` input 1: 1 selects 3 ticks/bit; 0 selects `OS_DEFAULT` ticks/bit.
- `tx_data` input 8: byte to enqueue.
- `tx_valid` input 1: enqueue request.
- `tx_ready` output 1: equals `!fifo_full`.
- `txd` output 1: serial line, registered, idle high.
- `busy` output 1: high while a frame is on the line.
- `fifo_empty` output 1: FIFO holds no entries.
- `fifo_full` output 1: FIFO holds `FIFO_DEPTH` entries.
- `tx_done` output 1: one-cycle pulse when the last stop bit completes.

## Operation
- Enqueue: a byte is written when `tx_valid && tx_ready` on a clock edge. `tx_valid` with the FIFO full is ignored and the byte is dropped; the FIFO and pointers do not change.
- Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full = MSBs differ and LSBs are equal. Empty = pointers equal.
- Simultaneous push and pop are both performed, and the count is unchanged. A push while full, in the same cycle as a pop, is still rejected, because `tx_ready` is evaluated from current state.
- State machine states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE → START when `!fifo_empty`. On that edge the block pops the head into the shift register. It also latches the effective data bits (`nbits`), the stop count and ticks/bit (`os`) into frame registers. CNTRL0 changes mid-frame do not affect the current frame.
  - Leaving START, DATA, PARITY or STOP happens on the `baud_tick` where `tick_cnt == os-1`. `tick_cnt` then clears, and `tick_cnt` only advances on `baud_tick`.
  - START → DATA. DATA shifts out LSB-first, using `bit_cnt` 0..`nbits`-1, then goes to PARITY, or to STOP if the macro is absent.
  - STOP lasts 1 or 2 bit periods. It then asserts `tx_done` for one cycle. If the FIFO is non-empty it goes directly to START, popping on the same edge with no idle bit. Otherwise it goes to IDLE.
- `txd` values by state: 1 in IDLE and STOP; 0 in START; `shift[0]` in DATA; the parity bit in PARITY.
- `busy` = state != IDLE.
- Reset, whether at rest or mid-frame, returns to IDLE immediately, empties the FIFO and leaves a truncated frame on the line.

## Timing
- Reset values: `txd`=1, `busy`=0, `fifo_empty`=1, `fifo_full`=0, `tx_ready`=1, `tx_done`=0. State is IDLE; all counters and pointers are 0.
- Push to `fifo_empty` low takes 1 cycle. Then `fifo_empty` to START takes 1 more edge, and `txd` falls on that edge. The push-to-`txd`-fall latency is 2 cycles when idle.
- A bit is `os` baud ticks long. A frame is (1 + `nbits` + parity + stops) × `os` ticks.
- `tx_done` is asserted in the cycle after the final tick edge, coincident with the state change.
- `fifo_full` and `fifo_empty` are registered-pointer derived and valid the cycle after the push/pop.

## Configuration
- `UART_TX_PARITY_EN` defined: adds the PARITY state, transmitting one even-parity bit (XOR of the `nbits` data bits) after DATA.
- `UART_TX_PARITY_EN` undefined: there is no parity state and DATA goes directly to STOP; the frame format is otherwise identical.

## Test plan
- Reset mid-frame: deassert `reset_n` during DATA → `txd`=1, `busy`=0 and `fifo_empty`=1 asynchronously. The next push starts a fresh frame.
- 8N1, os=16: push 0xA5 → `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each 16 ticks. `tx_done` pulses once; `busy` falls the same cycle.
- 5 data bits, 2 stop, os=3: `word_length`=3 (clamped to 5) and push 0x1F. Expect start, five 1s and two stop bits, each 3 ticks, for a total of 24 ticks.
- FIFO full: with depth 4, push 6 bytes back-to-back while idle. Bytes 1–5 are accepted: the first is popped immediately, which leaves room for four more. `tx_ready`=0 on the 6th, which is dropped. Frames are sent back-to-back with no idle gap between stop and start.
- Config change mid-frame: switch `oversample_by_3` 0→1 during DATA of the first byte. The first frame stays at 16 ticks/bit and the second uses 3.
- With `UART_TX_PARITY_EN`: push 0x07 with 8 bits → parity bit 1, transmitted between data bit 7 and stop.
